sdram_port_arbiter: RTL and testbench
=====================================

Name:
sdram_port_arbiter

Overview:
- Shares the single Avalon-style SDRAM controller port (`interface_*`) between two requesters. m0 is the VGA frame reader (latency-critical); m1 is the image-processing engine.
- Tags every accepted read so returning `readdatavalid` beats go to the right requester.
- Sits between the requesters and the `interface_*` port of the system interconnect.

Parameters:
- ADDR_W, 25, address width
- DATA_W, 16, data width
- BE_W, 2, byte-enable width
- MAX_PENDING, 8, maximum outstanding reads; tag FIFO depth, power of 2, ≥2
- BURST_MAX, 16, maximum accepted transfers per grant while the other requester waits

Ports:
- clk_clk  in  1  single clock
- reset_reset_n  in  1  asynchronous active-low reset
- mX_address  in  ADDR_W  requester X (X = 0, 1) word address
- mX_byteenable_n  in  BE_W  active-low byte enables
- mX_chipselect  in  1  request qualifier
- mX_writedata  in  DATA_W  write data
- mX_read_n  in  1  active-low read
- mX_write_n  in  1  active-low write
- mX_readdata  out  DATA_W  read data, valid with mX_readdatavalid
- mX_readdatavalid  out  1  read beat for requester X
- mX_waitrequest  out  1  transfer stalled
- interface_address  out  ADDR_W  to SDRAM port
- interface_byteenable_n  out  BE_W
- interface_chipselect  out  1
- interface_writedata  out  DATA_W
- interface_read_n  out  1
- interface_write_n  out  1
- interface_readdata  in  DATA_W
- interface_readdatavalid  in  1
- interface_waitrequest  in  1
- tag_err  out  1  sticky: readdatavalid arrived with an empty tag FIFO

Behaviour:
- **Request definition:** reqX = mX_chipselect & (~mX_read_n | ~mX_write_n). Read and write both low is illegal; read wins.
- **States:** IDLE, GNT0, GNT1 (registered).
  - IDLE → GNT0 if req0, else GNT1 if req1. The decision takes one cycle; nothing is forwarded while in IDLE.
  - GNTx → IDLE when reqx is low.
  - GNTx → GNTy directly when the burst counter reaches BURST_MAX and reqy is high.
- **Burst counter:** `$clog2(BURST_MAX+1)` bits, cleared on every grant change, incremented on each accepted transfer. It saturates, so a lone requester keeps its grant indefinitely.
- **Forwarding in GNTx:** the interface outputs are a combinational copy of mX_*. In IDLE: chipselect = 0, read_n = write_n = 1, address/data/byteenable_n hold 0/0/all-ones.
- **Read blocking:** when the tag FIFO is full, a granted read is not forwarded (interface_chipselect = 0) and mX_waitrequest = 1. Writes are unaffected.
- **Waitrequest:** mX_waitrequest = ~(GNTx) | interface_waitrequest | (read & fifo_full). Waitrequest is 1 for a requester with no request outstanding.
- **Accepted transfer:** interface_chipselect & ~interface_waitrequest.
  - An accepted read pushes tag x.
  - interface_readdatavalid pops the FIFO head t and asserts mt_readdatavalid in the same cycle (combinational).
  - Push and pop in the same cycle are legal, including when the FIFO is full.
- **Read data:** mX_readdata = interface_readdata for both requesters.
- **Tag error:** readdatavalid with an empty FIFO → beat dropped, tag_err set until reset.
- **Reset (asynchronous):**
  - State goes to IDLE; counter, FIFO and tag_err clear.
  - All mX_readdatavalid = 0, all mX_waitrequest = 1, interface_chipselect = 0.
  - Outstanding read tags are discarded. The SDRAM controller shares this reset, so no stale beats follow.

Optional Feature:
- Macro: SDRAM_ARB_PERF_EN.
- Defined: adds per-requester 32-bit wrapping counters.
  - Output ports mX_xfer_cnt (accepted transfers) and mX_stall_cnt (cycles with reqx & mX_waitrequest).
  - Both clear on reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sdram_arb_pkg: state enum (IDLE/GNT0/GNT1), tag type (1 bit), default parameter constants.
- Sub-module: sdram_arb_tag_fifo.
  - MAX_PENDING-deep, 1-bit-wide synchronous FIFO.
  - Outputs: full, empty, head; same-cycle push/pop.

Test Plan:
1. m0 alone reads addr 0x10, 0x11, 0x12 with a 3-cycle read latency from a model controller → three m0_readdatavalid beats in order, m1_readdatavalid never asserted, tag_err = 0.
2. Both requesters issue continuous writes, BURST_MAX = 16 → m0 gets exactly 16 accepts, then GNT1 with no IDLE cycle, m1 gets 16, and the pattern alternates.
3. Interleaved reads m0, m1, m0 with out-of-grant returns → each beat is routed to the issuing requester in issue order.
4. Controller withholds readdatavalid; m1 issues 9 reads with MAX_PENDING = 8 → 8 accepted, 9th stalled with interface_chipselect = 0; the first return unblocks it the same cycle the pop occurs.
5. Spurious interface_readdatavalid with an empty FIFO → no mX_readdatavalid, tag_err = 1 and held until reset.
6. Assert reset_reset_n low mid-burst with 4 reads pending → outputs take reset values immediately (asynchronously), FIFO empty, and the next request is granted 1 cycle after release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    // Grant state of the arbiter; IDLE forwards nothing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Read tag: which requester issued an outstanding read (0 = m0, 1 = m1).
    typedef logic tag_t;

    localparam int DEF_ADDR_W      = 25;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_BE_W        = 2;
    localparam int DEF_MAX_PENDING = 8;
    localparam int DEF_BURST_MAX   = 16;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO for outstanding reads: DEPTH entries of 1 bit, same-cycle push/pop
// allowed even when full. DEPTH must be a power of two so pointers wrap freely.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_PENDING
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO only lands when a pop frees the slot this cycle.
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller port. m0 (VGA reader)
// wins ties from IDLE; a grant is held while its requester keeps requesting,
// and handed over after BURST_MAX accepts if the other side is waiting.
// Every accepted read is tagged so returning beats reach the issuer.
// Optional build macro SDRAM_ARB_PERF_EN adds per-requester transfer/stall counters.
//
// Handshake: a requester transfer completes in a cycle where it drives a request
// and sees mX_waitrequest low; the interface side completes a transfer when
// interface_chipselect is high and interface_waitrequest is low. Read beats are
// single-cycle pulses on readdatavalid with no back-pressure.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BE_W        = DEF_BE_W,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int BURST_MAX   = DEF_BURST_MAX
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable_n,
    input  logic              m0_chipselect,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_read_n,
    input  logic              m0_write_n,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable_n,
    input  logic              m1_chipselect,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_read_n,
    input  logic              m1_write_n,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] interface_address,
    output logic [BE_W-1:0]   interface_byteenable_n,
    output logic              interface_chipselect,
    output logic [DATA_W-1:0] interface_writedata,
    output logic              interface_read_n,
    output logic              interface_write_n,
    input  logic [DATA_W-1:0] interface_readdata,
    input  logic              interface_readdatavalid,
    input  logic              interface_waitrequest,
    output logic              tag_err,
    output logic [1:0]        arb_state
`ifdef SDRAM_ARB_PERF_EN
    ,
    output logic [31:0]       m0_xfer_cnt,
    output logic [31:0]       m0_stall_cnt,
    output logic [31:0]       m1_xfer_cnt,
    output logic [31:0]       m1_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_nxt;
    logic             burst_done;
    logic             req0, req1, rd0, rd1;
    logic             gnt0, gnt1;
    logic             fifo_full, fifo_empty, fifo_head;
    logic             rd_block;
    logic             accept, push, pop;

    assign req0 = m0_chipselect & (~m0_read_n | ~m0_write_n);
    assign req1 = m1_chipselect & (~m1_read_n | ~m1_write_n);
    assign rd0  = m0_chipselect & ~m0_read_n;
    assign rd1  = m1_chipselect & ~m1_read_n;
    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    // A full FIFO only blocks reads when no beat is returning this cycle;
    // a returning beat frees a slot, so the stalled read goes out immediately.
    assign rd_block = fifo_full & ~interface_readdatavalid;

    assign accept = interface_chipselect & ~interface_waitrequest;
    assign push   = accept & ~interface_read_n;
    assign pop    = interface_readdatavalid & ~fifo_empty;

    assign m0_waitrequest = ~gnt0 | ~req0 | interface_waitrequest | (rd0 & rd_block);
    assign m1_waitrequest = ~gnt1 | ~req1 | interface_waitrequest | (rd1 & rd_block);

    assign m0_readdata      = interface_readdata;
    assign m1_readdata      = interface_readdata;
    assign m0_readdatavalid = pop & ~fifo_head;
    assign m1_readdatavalid = pop & fifo_head;
    assign arb_state        = state;

    // Saturating burst count including this cycle's accept.
    assign burst_cnt_nxt = burst_cnt + {{(CNT_W-1){1'b0}}, (accept && burst_cnt != CNT_MAX)};
    assign burst_done    = (burst_cnt_nxt == CNT_MAX);

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (push),
        .push_tag (gnt1),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Grant state, burst counter and sticky tag error.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            tag_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= (state_nxt != state) ? '0 : burst_cnt_nxt;
            if (interface_readdatavalid && fifo_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

    // Next grant: release on idle requester, hand over after a full burst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0)      state_nxt = GNT0;
                else if (req1) state_nxt = GNT1;
            end
            GNT0: begin
                if (!req0)                   state_nxt = IDLE;
                else if (burst_done && req1) state_nxt = GNT1;
            end
            GNT1: begin
                if (!req1)                   state_nxt = IDLE;
                else if (burst_done && req0) state_nxt = GNT0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Forward the granted requester to the controller; read wins over write.
    always_comb begin
        interface_address      = '0;
        interface_byteenable_n = '1;
        interface_chipselect   = 1'b0;
        interface_writedata    = '0;
        interface_read_n       = 1'b1;
        interface_write_n      = 1'b1;
        if (gnt0) begin
            interface_address      = m0_address;
            interface_byteenable_n = m0_byteenable_n;
            interface_chipselect   = req0 & ~(rd0 & rd_block);
            interface_writedata    = m0_writedata;
            interface_read_n       = m0_read_n;
            interface_write_n      = m0_write_n | ~m0_read_n;
        end else if (gnt1) begin
            interface_address      = m1_address;
            interface_byteenable_n = m1_byteenable_n;
            interface_chipselect   = req1 & ~(rd1 & rd_block);
            interface_writedata    = m1_writedata;
            interface_read_n       = m1_read_n;
            interface_write_n      = m1_write_n | ~m1_read_n;
        end
    end

`ifdef SDRAM_ARB_PERF_EN
    // Wrapping per-requester accepted-transfer and stall-cycle counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m0_xfer_cnt  <= '0;
            m0_stall_cnt <= '0;
            m1_xfer_cnt  <= '0;
            m1_stall_cnt <= '0;
        end else begin
            if (accept && gnt0)         m0_xfer_cnt  <= m0_xfer_cnt + 1'b1;
            if (accept && gnt1)         m1_xfer_cnt  <= m1_xfer_cnt + 1'b1;
            if (req0 && m0_waitrequest) m0_stall_cnt <= m0_stall_cnt + 1'b1;
            if (req1 && m1_waitrequest) m1_stall_cnt <= m1_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: requester drivers, a controller model with
// in-order read returns, and a scoreboard that checks routing and forwarding.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] m_addr [2];
    logic [BE_W-1:0]   m_be_n [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [DATA_W-1:0] m_rdata [2];
    logic [1:0]        m_cs, m_rd_n, m_wr_n, m_rdv, m_wait;

    logic [ADDR_W-1:0] if_addr;
    logic [BE_W-1:0]   if_be_n;
    logic [DATA_W-1:0] if_wdata;
    logic [DATA_W-1:0] if_rdata = '0;
    logic              if_cs, if_rd_n, if_wr_n;
    logic              if_rdv = 1'b0;
    logic              if_wait = 1'b0;
    logic              tag_err;
    logic [1:0]        arb_state;
`ifdef SDRAM_ARB_PERF_EN
    logic [31:0] m0_xfer_cnt, m0_stall_cnt, m1_xfer_cnt, m1_stall_cnt;
`endif

    sdram_port_arbiter dut (
        .clk_clk                 (clk),
        .reset_reset_n           (rst_n),
        .m0_address              (m_addr[0]),
        .m0_byteenable_n         (m_be_n[0]),
        .m0_chipselect           (m_cs[0]),
        .m0_writedata            (m_wdata[0]),
        .m0_read_n               (m_rd_n[0]),
        .m0_write_n              (m_wr_n[0]),
        .m0_readdata             (m_rdata[0]),
        .m0_readdatavalid        (m_rdv[0]),
        .m0_waitrequest          (m_wait[0]),
        .m1_address              (m_addr[1]),
        .m1_byteenable_n         (m_be_n[1]),
        .m1_chipselect           (m_cs[1]),
        .m1_writedata            (m_wdata[1]),
        .m1_read_n               (m_rd_n[1]),
        .m1_write_n              (m_wr_n[1]),
        .m1_readdata             (m_rdata[1]),
        .m1_readdatavalid        (m_rdv[1]),
        .m1_waitrequest          (m_wait[1]),
        .interface_address       (if_addr),
        .interface_byteenable_n  (if_be_n),
        .interface_chipselect    (if_cs),
        .interface_writedata     (if_wdata),
        .interface_read_n        (if_rd_n),
        .interface_write_n       (if_wr_n),
        .interface_readdata      (if_rdata),
        .interface_readdatavalid (if_rdv),
        .interface_waitrequest   (if_wait),
        .tag_err                 (tag_err),
        .arb_state               (arb_state)
`ifdef SDRAM_ARB_PERF_EN
        ,
        .m0_xfer_cnt             (m0_xfer_cnt),
        .m0_stall_cnt            (m0_stall_cnt),
        .m1_xfer_cnt             (m1_xfer_cnt),
        .m1_stall_cnt            (m1_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard queues: expected read beats {tag, data} in issue order and
    // expected writes {be_n, addr, data} in acceptance order.
    logic [16:0] exp_rd_q [$];
    logic [42:0] exp_wr_q [$];
    // Controller model: pending read data and the cycle each may return.
    logic [15:0] pend_d [$];
    int          pend_due [$];
    logic        own_q [$];

    int ret_budget = 1 << 30;
    int lat_fixed  = 0;
    bit wait_rand  = 1'b0;
    bit wait_force = 1'b0;
    bit spur_pulse = 1'b0;
    bit burst_log  = 1'b0;
    int gaps       = 0;
    int rd_acc_cnt = 0;

    function automatic logic [15:0] mem_f(input logic [24:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {7'd0, a[24:16]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: waitrequest pattern and in-order read returns.
    always @(posedge clk) begin
        #1;
        if_rdv   = 1'b0;
        if_rdata = '0;
        if (rst_n) begin
            if (spur_pulse) begin
                if_rdv     = 1'b1;
                if_rdata   = 16'hDEAD;
                spur_pulse = 1'b0;
            end else if (ret_budget > 0 && pend_d.size() > 0 && pend_due[0] <= cyc) begin
                if_rdv   = 1'b1;
                if_rdata = pend_d.pop_front();
                void'(pend_due.pop_front());
                ret_budget--;
            end
        end
        if_wait = wait_force ? 1'b1 : (wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
    end

    // Monitor: routes returned beats against the scoreboard, checks writes,
    // and records accepted reads for the controller model.
    always @(negedge clk) begin
        logic [16:0] e;
        int lat;
        #1;
        if (rst_n) begin
            if (m_rdv[0] && m_rdv[1]) begin
                checks++; errors++;
                $display("FAIL rdv_both actual=2 required=1");
            end
            for (int x = 0; x < 2; x++) begin
                if (m_rdv[x]) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected m%0d actual=beat required=none", x);
                    end else begin
                        e = exp_rd_q.pop_front();
                        check("rd_tag", 64'(x), 64'(e[16]));
                        check("rd_data", 64'(m_rdata[x]), 64'(e[15:0]));
                    end
                end
            end
            if (burst_log && own_q.size() > 0 && own_q.size() < 64 && !if_cs) gaps++;
            if (if_cs && !if_wait) begin
                if (!if_rd_n) begin
                    lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                    rd_acc_cnt++;
                    pend_d.push_back(mem_f(if_addr));
                    pend_due.push_back(cyc + lat);
                end else if (!if_wr_n) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected actual=%0h required=none", if_addr);
                    end else begin
                        check("wr_fwd", 64'({if_be_n, if_addr, if_wdata}), 64'(exp_wr_q.pop_front()));
                    end
                    if (burst_log) own_q.push_back(if_addr[24]);
                end
            end
        end
    end

    // Requester driver: hold one transfer until accepted, record its expectation.
    task automatic issue(input int x, input bit rd, input logic [24:0] a, input logic [15:0] d);
        int n = 0;
        m_addr[x]  = a;
        m_wdata[x] = d;
        m_be_n[x]  = 2'($urandom_range(0, 3));
        m_cs[x]    = 1'b1;
        m_rd_n[x]  = ~rd;
        m_wr_n[x]  = rd;
        forever begin
            @(negedge clk);
            if (!m_wait[x]) begin
                if (rd) exp_rd_q.push_back({x[0], mem_f(a)});
                else    exp_wr_q.push_back({m_be_n[x], a, d});
                break;
            end
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL issue_timeout m%0d actual=stalled required=accepted", x);
                break;
            end
        end
        @(posedge clk); #1;
        m_cs[x]   = 1'b0;
        m_rd_n[x] = 1'b1;
        m_wr_n[x] = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rd_q.size() != 0 || pend_d.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(exp_rd_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        for (int x = 0; x < 2; x++) begin
            m_addr[x] = '0; m_be_n[x] = '1; m_wdata[x] = '0;
        end
        m_cs = 2'b00; m_rd_n = 2'b11; m_wr_n = 2'b11;

        // Reset values.
        #2;
        check("rst_wait0", 64'(m_wait[0]), 64'd1);
        check("rst_wait1", 64'(m_wait[1]), 64'd1);
        check("rst_rdv", 64'(m_rdv), 64'd0);
        check("rst_if_cs", 64'(if_cs), 64'd0);
        check("rst_if_rw", 64'({if_rd_n, if_wr_n, if_be_n}), 64'hF);
        check("rst_tag_err", 64'(tag_err), 64'd0);
        check("rst_state_idle", 64'(arb_state), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // m0 alone: three reads with a 3-cycle return latency.
        lat_fixed = 3;
        for (int i = 0; i < 3; i++) issue(0, 1'b1, 25'h10 + 25'(i), '0);
        drain("m0_reads_drain");
        check("m0_reads_tag_err", 64'(tag_err), 64'd0);

        // Interleaved reads with returns arriving under a different grant.
        lat_fixed = 4;
        issue(0, 1'b1, 25'h20, '0);
        issue(1, 1'b1, 25'h1000021, '0);
        issue(0, 1'b1, 25'h22, '0);
        drain("interleave_drain");

        // Both requesters stream writes: 16-accept bursts, no idle cycle between.
        own_q.delete(); gaps = 0; burst_log = 1'b1;
        fork
            begin for (int i = 0; i < 40; i++) issue(0, 1'b0, 25'(i), 16'(i)); end
            begin for (int i = 0; i < 40; i++) issue(1, 1'b0, 25'h1000000 | 25'(i), 16'(i + 100)); end
        join
        burst_log = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++) if (own_q[i] != 1'((i / 16) % 2)) bad++;
        check("burst_pattern", 64'(bad), 64'd0);
        check("burst_total", 64'(own_q.size()), 64'd80);
        check("burst_gaps", 64'(gaps), 64'd0);

        // Random mixed traffic, random waitrequest and read latency.
        lat_fixed = 0; wait_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    issue(0, 1'($urandom_range(0, 1)), 25'($urandom), 16'($urandom));
                    if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    issue(1, 1'($urandom_range(0, 1)), 25'($urandom), 16'($urandom));
                    if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
                end
            end
        join
        wait_rand = 1'b0;
        drain("random_drain");
        check("random_tag_err", 64'(tag_err), 64'd0);

        // Tag FIFO full: 9 reads with returns withheld; 9th waits for a pop.
        ret_budget = 0; lat_fixed = 1; rd_acc_cnt = 0;
        fork
            begin for (int i = 0; i < 9; i++) issue(1, 1'b1, 25'h1000040 | 25'(i), '0); end
        join_none
        repeat (20) @(negedge clk);
        #2;
        check("full_accepted", 64'(rd_acc_cnt), 64'd8);
        check("full_blocked_cs", 64'(if_cs), 64'd0);
        check("full_blocked_wait", 64'(m_wait[1]), 64'd1);
        @(posedge clk);
        ret_budget = 1;
        @(negedge clk); #2;
        check("unblock_cs", 64'(if_cs), 64'd1);
        check("unblock_beat", 64'(m_rdv[1]), 64'd1);
        ret_budget = 1 << 30;
        drain("full_drain");

        // Spurious return with nothing outstanding: dropped, sticky error.
        spur_pulse = 1'b1;
        repeat (3) @(negedge clk);
        #2 check("spur_tag_err", 64'(tag_err), 64'd1);
        repeat (10) @(negedge clk);
        #2 check("spur_tag_err_held", 64'(tag_err), 64'd1);

        // Reset mid-burst with 4 reads outstanding and a stalled 5th.
        @(posedge clk); #1;
        ret_budget = 0; lat_fixed = 2;
        for (int i = 0; i < 4; i++) issue(0, 1'b1, 25'h100 + 25'(i), '0);
        wait_force = 1'b1;
        @(posedge clk); #2;
        m_addr[0] = 25'h104; m_cs[0] = 1'b1; m_rd_n[0] = 1'b0; m_wr_n[0] = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_wait0", 64'(m_wait[0]), 64'd1);
        check("arst_wait1", 64'(m_wait[1]), 64'd1);
        check("arst_rdv", 64'(m_rdv), 64'd0);
        check("arst_if_cs", 64'(if_cs), 64'd0);
        check("arst_tag_err", 64'(tag_err), 64'd0);
        pend_d.delete(); pend_due.delete(); exp_rd_q.delete(); exp_wr_q.delete();
        m_cs[0] = 1'b0; m_rd_n[0] = 1'b1; wait_force = 1'b0; ret_budget = 1 << 30;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        m_addr[0] = 25'h55; m_wdata[0] = 16'h1234; m_be_n[0] = 2'b00;
        m_cs[0] = 1'b1; m_wr_n[0] = 1'b0;
        exp_wr_q.push_back({2'b00, 25'h55, 16'h1234});
        @(negedge clk); #2;
        check("post_rst_idle_cs", 64'(if_cs), 64'd0);
        @(negedge clk); #2;
        check("post_rst_grant_cs", 64'(if_cs), 64'd1);
        check("post_rst_grant_wait", 64'(m_wait[0]), 64'd0);
        @(posedge clk); #1;
        m_cs[0] = 1'b0; m_wr_n[0] = 1'b1;
        // Stale tags must be gone: a return now is spurious.
        spur_pulse = 1'b1;
        repeat (3) @(negedge clk);
        #2 check("post_rst_fifo_empty", 64'(tag_err), 64'd1);
        check("post_rst_wr_q", 64'(exp_wr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
